prince_minv_serial: RTL and testbench
=====================================

# prince_minv_serial

Masked, round-based inverse linear layer for the PRINCE core. It computes M⁻¹ = M' ∘ SR⁻¹, the counterpart of the forward layer M = SR ∘ M', independently on each Boolean share. The M' part is evaluated one 16-bit chunk per cycle behind a valid/ready handshake. It sits between the inverse S-box stage and the round-key addition in the backward half of the unrolled/round-based encryption datapath.

## Interface
- NUM_SHARES, 2, number of Boolean shares (d+1; d=1 default)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept a state
- in_shares  in  64*NUM_SHARES  share s at bits [64s+63:64s]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_shares  out  64*NUM_SHARES  M⁻¹ applied per share, same layout

Clock `clk`, reset `rst`: one clock; reset is asynchronous and active-high.

## Operation
- Nibble i means bits [63-4i -: 4], so nibble 0 is the most significant nibble.
- SR⁻¹: output nibble i = input nibble P[i], with P = (0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3). This is pure wiring, applied on capture.
- Chunk k means bits [16k+15:16k]. Chunks 0 and 3 use M̂0; chunks 1 and 2 use M̂1.
- Within a chunk, out[4r+c] = XOR over s∈{0..3} of in[4s+c], excluding one value of s:
  - M̂0 excludes s = (c−r+3) mod 4.
  - M̂1 excludes s = (c−r) mod 4.
- Every share is processed identically. Shares are never combined and no randomness is used.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture SR⁻¹(in_shares) into the state register, clear the output register to 0, set cnt=0, go to BUSY.
  - BUSY: write chunk cnt of every share into the output register and increment cnt. After cnt=3 is written, go to DONE.
  - DONE: out_valid=1, out_shares held stable. On out_ready, go to IDLE.
- in_ready=0 outside IDLE. There is no overlap of consecutive states, which keeps share transitions of distinct inputs separated.
- out_valid and out_ready high together in DONE counts as a transfer. in_valid in the same cycle is ignored; it is accepted in the following IDLE cycle.
- Reset at any point, including mid-BUSY: state=IDLE, cnt=0, state and output registers=0, out_valid=0, in_ready=1 right after reset release.

## Timing
- Reset values: in_ready=1, out_valid=0, out_shares=0.
- Capture at edge E0. Chunks 0..3 are written at edges E1..E4. out_valid is high from E4.
- Latency from accept to out_valid is 4 cycles. Minimum throughput is 1 state per 6 cycles (accept, 4×BUSY, DONE).
- out_shares changes only at the clear on accept and at the chunk writes. It is constant while out_valid=1.
- out_ready held low keeps DONE indefinitely.

## Configuration
- PRINCE_MINV_PARALLEL_EN defined: BUSY lasts one cycle and all four chunks are written at E1. Latency is 1 cycle and cnt is removed.
- PRINCE_MINV_PARALLEL_EN undefined: 4-chunk serial behaviour as above.
- Handshake, reset and results are identical in both modes.

## Structure
- The shared package `prince_pkg` holds:
  - the SR⁻¹ permutation constant P;
  - the functions `mhat0`/`mhat1` (16→16);
  - the state-width constant 64;
  - the FSM state enum {IDLE, BUSY, DONE}.
- One sub-module: `prince_mprime_chunk`, one 16-bit share chunk with a select input for M̂0/M̂1. It is instantiated NUM_SHARES times, or 4×NUM_SHARES under PARALLEL.

## Test plan
- Zero state: in_shares = 0 → out_shares = 0 after 4 cycles.
- Single bit: share0 = 64'h0000_0000_0000_0001, share1 = 0 → share0 out = 64'h0000_0000_1110_0000, share1 out = 0, out_valid at E4.
- Round trip: 1000 random share pairs, checked against two references:
  - XOR of output shares = M⁻¹(XOR of input shares);
  - forward M applied to the output returns the input.
- Backpressure: hold out_ready low for 5 cycles in DONE → out_shares stable, in_ready=0, a concurrent in_valid is not accepted; raise out_ready → IDLE next cycle, then the pending input is accepted.
- Reset mid-operation: assert rst at cnt=2 → out_valid=0, out_shares=0, in_ready=1 after release; the next accept completes correctly.
- PRINCE_MINV_PARALLEL_EN build: repeat the single-bit case → same value with out_valid at E1.

Source files
------------

// File: rtl/prince_pkg.sv
// Shared PRINCE constants, FSM state type and the SR^-1 / M-hat helper functions.
// Purely combinational helpers; no clocked state lives here.
package prince_pkg;

    localparam int STATE_W    = 64;
    localparam int CHUNK_W    = 16;
    localparam int NUM_CHUNKS = STATE_W / CHUNK_W;

    // Nibble i (MSB-first) of the SR^-1 output is taken from input nibble P[i].
    localparam logic [63:0] SR_INV_P = 64'h0DA7_41EB_852F_C963;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [STATE_W-1:0] sr_inv(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] y;
        int                 src;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src = int'(SR_INV_P[63-4*i -: 4]);
            y[63-4*i -: 4] = x[63-4*src -: 4];
        end
        return y;
    endfunction

    // Each output bit sums three of the four same-column bits; the dropped row
    // is a reflection in (c - r), which makes both matrices involutions.
    function automatic logic [CHUNK_W-1:0] mhat0(input logic [CHUNK_W-1:0] x);
        logic [CHUNK_W-1:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int s = 0; s < 4; s++) begin
                    if (s != (c - r + 7) % 4) begin
                        y[4*r+c] = y[4*r+c] ^ x[4*s+c];
                    end
                end
            end
        end
        return y;
    endfunction

    function automatic logic [CHUNK_W-1:0] mhat1(input logic [CHUNK_W-1:0] x);
        logic [CHUNK_W-1:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int s = 0; s < 4; s++) begin
                    if (s != (c - r + 4) % 4) begin
                        y[4*r+c] = y[4*r+c] ^ x[4*s+c];
                    end
                end
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/prince_minv_serial_if.sv
// Valid/ready bundle carrying masked 64-bit states into and out of the inverse linear layer.
// master = producer/consumer side, slave = the inverse-layer block.
interface prince_minv_serial_if #(
    parameter int NUM_SHARES = 2
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [prince_pkg::STATE_W*NUM_SHARES-1:0] in_shares;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [prince_pkg::STATE_W*NUM_SHARES-1:0] out_shares;

    modport master (
        output in_valid,
        output in_shares,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_shares
    );

    modport slave (
        input  in_valid,
        input  in_shares,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_shares
    );
endinterface

// File: rtl/prince_mprime_chunk.sv
// M' on one 16-bit chunk of one share; sel_m1 picks M-hat1 over M-hat0.
// Combinational, zero latency, no handshake.
module prince_mprime_chunk
    import prince_pkg::*;
(
    input  logic               sel_m1,
    input  logic [CHUNK_W-1:0] din,
    output logic [CHUNK_W-1:0] dout
);

    assign dout = sel_m1 ? mhat1(din) : mhat0(din);

endmodule

// File: rtl/prince_minv_serial.sv
// Masked PRINCE inverse linear layer (M' after SR^-1), share-wise, one chunk per cycle.
// Latency 4 (1 with PRINCE_MINV_PARALLEL_EN); holds result in DONE until out_ready, in_ready only in IDLE.
module prince_minv_serial
    import prince_pkg::*;
#(
    parameter int NUM_SHARES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    prince_minv_serial_if.slave  bus
);

    localparam int SW = STATE_W * NUM_SHARES;

    state_e        state_q, state_d;
    logic [SW-1:0] st_q, st_d;
    logic [SW-1:0] res_q, res_d;

`ifdef PRINCE_MINV_PARALLEL_EN
    logic [SW-1:0] par_dout;

    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
        for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
            prince_mprime_chunk u_chunk (
                .sel_m1 ((k == 1) || (k == 2)),
                .din    (st_q[s*STATE_W + k*CHUNK_W +: CHUNK_W]),
                .dout   (par_dout[s*STATE_W + k*CHUNK_W +: CHUNK_W])
            );
        end
    end
`else
    logic [1:0]         cnt_q, cnt_d;
    logic [CHUNK_W-1:0] chunk_dout [NUM_SHARES];

    // Chunks 1 and 2 (cnt 01/10) use M-hat1, chunks 0 and 3 use M-hat0.
    for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
        prince_mprime_chunk u_chunk (
            .sel_m1 (cnt_q[1] ^ cnt_q[0]),
            .din    (st_q[s*STATE_W + int'(cnt_q)*CHUNK_W +: CHUNK_W]),
            .dout   (chunk_dout[s])
        );
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            res_q   <= '0;
`ifndef PRINCE_MINV_PARALLEL_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            res_q   <= res_d;
`ifndef PRINCE_MINV_PARALLEL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        res_d   = res_q;
`ifndef PRINCE_MINV_PARALLEL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int s = 0; s < NUM_SHARES; s++) begin
                        st_d[s*STATE_W +: STATE_W] = sr_inv(bus.in_shares[s*STATE_W +: STATE_W]);
                    end
                    res_d   = '0;
`ifndef PRINCE_MINV_PARALLEL_EN
                    cnt_d   = '0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef PRINCE_MINV_PARALLEL_EN
                res_d   = par_dout;
                state_d = DONE;
`else
                for (int s = 0; s < NUM_SHARES; s++) begin
                    res_d[s*STATE_W + int'(cnt_q)*CHUNK_W +: CHUNK_W] = chunk_dout[s];
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // A same-cycle in_valid is left pending until the next IDLE cycle.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_shares = res_q;

endmodule

// File: tb/tb_prince_minv_serial.sv
// Directed bench for prince_minv_serial: reset, latency, known vectors, backpressure,
// mid-operation reset and a random round trip against an independent reference.
module tb_prince_minv_serial;

`ifdef PRINCE_MINV_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    localparam int PERM [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    logic [127:0] snap;
    logic [63:0]  a0, a1, x_in, x_out;

    prince_minv_serial_if #(.NUM_SHARES(2)) bus ();

    prince_minv_serial #(.NUM_SHARES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sr_inv_m(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[63-4*i -: 4] = x[63-4*PERM[i] -: 4];
        return y;
    endfunction

    function automatic logic [63:0] sr_fwd_m(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[63-4*PERM[i] -: 4] = x[63-4*i -: 4];
        return y;
    endfunction

    // Column parity with the excluded row added back in.
    function automatic logic [63:0] mp_m(input logic [63:0] x);
        logic [63:0] y;
        int          ex;
        logic        p;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    ex = (k == 1 || k == 2) ? (c - r + 4) % 4 : (c - r + 7) % 4;
                    p  = x[16*k+c] ^ x[16*k+4+c] ^ x[16*k+8+c] ^ x[16*k+12+c];
                    y[16*k+4*r+c] = p ^ x[16*k+4*ex+c];
                end
            end
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] s0, input logic [63:0] s1);
        bus.in_valid  = 1'b1;
        bus.in_shares = {s1, s0};
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_shares = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_in_ready",  128'(bus.in_ready),  128'(1'b1));
        check("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("reset_out",       bus.out_shares,      128'h0);

        // Zero state
        send(64'h0, 64'h0);
        check("zero_in_ready_busy", 128'(bus.in_ready), 128'(1'b0));
        wait_out(lat);
        check("zero_latency", 128'(lat), 128'(LAT));
        check("zero_out", bus.out_shares, 128'h0);
        release_out();
        check("zero_back_idle", 128'(bus.in_ready), 128'(1'b1));

        // Single bit in each share, hand-derived results
        send(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check("bit_valid_early", 128'(bus.out_valid), 128'(1'b0));
        end
        tick();
        check("bit_valid_at_lat", 128'(bus.out_valid), 128'(1'b1));
        check("bit_out", bus.out_shares, {64'h0888_0000_0000_0000, 64'h0000_0000_1110_0000});
        release_out();
        check("bit_idle_valid", 128'(bus.out_valid), 128'(1'b0));

        // Backpressure in DONE with a competing in_valid
        send(64'h8000_0000_0000_0000, 64'h0);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'(LAT));
        snap = bus.out_shares;
        check("bp_out", snap, {64'h0, 64'h0888_0000_0000_0000});
        bus.in_valid  = 1'b1;
        bus.in_shares = {64'h0000_0000_0000_0001, 64'h0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 128'(bus.out_valid), 128'(1'b1));
            check("bp_hold_ready", 128'(bus.in_ready),  128'(1'b0));
            check("bp_hold_data",  bus.out_shares,      snap);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_ready", 128'(bus.in_ready),  128'(1'b1));
        check("bp_idle_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        bus.in_valid = 1'b0;
        check("bp_pending_accepted", 128'(bus.in_ready), 128'(1'b0));
        wait_out(lat);
        check("bp_pending_latency", 128'(lat), 128'(LAT));
        check("bp_pending_out", bus.out_shares, {64'h0000_0000_1110_0000, 64'h0});
        release_out();

        // Reset in the middle of BUSY
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("mrst_out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("mrst_out",       bus.out_shares,      128'h0);
        check("mrst_in_ready",  128'(bus.in_ready),  128'(1'b1));
        send(64'h0000_0000_0000_0001, 64'h0);
        wait_out(lat);
        check("mrst_latency", 128'(lat), 128'(LAT));
        check("mrst_out_after", bus.out_shares, {64'h0, 64'h0000_0000_1110_0000});
        release_out();

        // Random round trip
        for (int n = 0; n < 1000; n++) begin
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            send(a0, a1);
            wait_out(lat);
            check("rnd_latency", 128'(lat), 128'(LAT));
            x_in  = a0 ^ a1;
            x_out = bus.out_shares[63:0] ^ bus.out_shares[127:64];
            check("rnd_minv",    128'(x_out), 128'(mp_m(sr_inv_m(x_in))));
            check("rnd_fwd_inv", 128'(sr_fwd_m(mp_m(x_out))), 128'(x_in));
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
